// File: rtl/insn_sequencer.sv
// Instruction-fetch sequencer: fetches 64-bit words, issues the left then the right half-instruction.
// Optional PREFETCH_EN macro adds a one-word prefetch buffer fetched during right-half issue.
module decoder (
    input  logic [63:0] word,
    input  logic        pe,
    input  logic        tkk,
    output logic [3:0]  ir,
    output logic [7:0]  op,
    output logic        extop,
    output logic [19:0] addr
);
    logic [31:0] half_word;

    always_comb begin
        half_word = tkk ? word[31:0] : word[63:32];
        ir        = half_word[31:28];
        extop     = half_word[27];
        op        = extop ? {1'b1, half_word[26:20]} : {3'b000, half_word[24:20]};
        // Compatibility mode narrows the address field to 15 bits
        addr      = pe ? {5'd0, half_word[14:0]} : half_word[19:0];
    end
endmodule

module insn_sequencer #(
    parameter int            AW       = 15,
    parameter logic [AW-1:0] START_PC = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pe,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [63:0]   mem_rdata,
    output logic          insn_valid,
    input  logic          insn_ready,
    output logic [3:0]    insn_ir,
    output logic [7:0]    insn_op,
    output logic          insn_extop,
    output logic [19:0]   insn_addr,
    output logic [AW-1:0] insn_pc,
    output logic          insn_tkk,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          redirect_tkk,
    output logic          busy
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic          half_reg, half_next;
    logic [63:0]   word_reg, word_next;
    logic          discard_reg, discard_next;
    logic          run_reg;
    logic          outstanding;
    logic [AW-1:0] pc_inc;
    logic [3:0]    dec_ir;
    logic [7:0]    dec_op;
    logic          dec_extop;
    logic [19:0]   dec_addr;
`ifdef PREFETCH_EN
    logic [63:0]   buf_reg, buf_next;
    logic          buf_valid_reg, buf_valid_next;
    logic          pf_out_reg, pf_out_next;
    logic          pf_req;
`endif

    assign pc_inc = pc_reg + 1'b1;

    decoder u_decoder (
        .word  (word_reg),
        .pe    (pe),
        .tkk   (half_reg),
        .ir    (dec_ir),
        .op    (dec_op),
        .extop (dec_extop),
        .addr  (dec_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_FETCH;
            pc_reg        <= START_PC;
            half_reg      <= 1'b0;
            word_reg      <= '0;
            discard_reg   <= 1'b0;
            run_reg       <= 1'b0;
`ifdef PREFETCH_EN
            buf_reg       <= '0;
            buf_valid_reg <= 1'b0;
            pf_out_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            half_reg      <= half_next;
            word_reg      <= word_next;
            discard_reg   <= discard_next;
            // Keeps mem_req low while reset is held, although the state is FETCH
            run_reg       <= 1'b1;
`ifdef PREFETCH_EN
            buf_reg       <= buf_next;
            buf_valid_reg <= buf_valid_next;
            pf_out_reg    <= pf_out_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        half_next    = half_reg;
        word_next    = word_reg;
        discard_next = discard_reg;
        outstanding  = 1'b0;
`ifdef PREFETCH_EN
        buf_next       = buf_reg;
        buf_valid_next = buf_valid_reg;
        pf_out_next    = pf_out_reg;
`endif
        case (state_reg)
            S_FETCH: begin
                if (mem_req && mem_gnt) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (discard_reg) begin
                        discard_next = 1'b0;
                        state_next   = S_FETCH;
                    end else begin
                        word_next  = mem_rdata;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
`ifdef PREFETCH_EN
                if (pf_req && mem_gnt) pf_out_next = 1'b1;
                if (pf_out_reg && mem_rvalid) begin
                    buf_next       = mem_rdata;
                    buf_valid_next = 1'b1;
                    pf_out_next    = 1'b0;
                end
`endif
                if (insn_ready) begin
                    if (!half_reg) begin
                        half_next = 1'b1;
                    end else begin
                        pc_next    = pc_inc;
                        half_next  = 1'b0;
                        state_next = S_FETCH;
`ifdef PREFETCH_EN
                        // Prefetched word (already held or arriving now) skips the refetch
                        if (buf_valid_reg) begin
                            word_next      = buf_reg;
                            buf_valid_next = 1'b0;
                            state_next     = S_ISSUE;
                        end else if (pf_out_reg && mem_rvalid) begin
                            word_next      = mem_rdata;
                            buf_valid_next = 1'b0;
                            state_next     = S_ISSUE;
                        end else if (pf_out_reg || (pf_req && mem_gnt)) begin
                            pf_out_next = 1'b0;
                            state_next  = S_WAIT;
                        end
`endif
                    end
                end
            end
            default: state_next = S_FETCH;
        endcase

        if (redirect) begin
            // Any read still owed by memory must be drained and dropped before refetching
            outstanding = (mem_req && mem_gnt) || (state_reg == S_WAIT && !mem_rvalid);
`ifdef PREFETCH_EN
            outstanding    = outstanding || (pf_out_reg && !mem_rvalid);
            buf_valid_next = 1'b0;
            pf_out_next    = 1'b0;
`endif
            pc_next      = redirect_pc;
            half_next    = redirect_tkk;
            discard_next = outstanding;
            state_next   = outstanding ? S_WAIT : S_FETCH;
        end
    end

    always_comb begin
        mem_req    = run_reg && (state_reg == S_FETCH);
        mem_addr   = pc_reg;
        insn_valid = (state_reg == S_ISSUE);
        busy       = (state_reg == S_WAIT);
`ifdef PREFETCH_EN
        pf_req = run_reg && (state_reg == S_ISSUE) && half_reg && !pf_out_reg && !buf_valid_reg;
        if (pf_req) begin
            mem_req  = 1'b1;
            mem_addr = pc_inc;
        end
        busy = busy || pf_out_reg;
`endif
        insn_ir    = insn_valid ? dec_ir    : '0;
        insn_op    = insn_valid ? dec_op    : '0;
        insn_extop = insn_valid ? dec_extop : 1'b0;
        insn_addr  = insn_valid ? dec_addr  : '0;
        insn_pc    = insn_valid ? pc_reg    : '0;
        insn_tkk   = insn_valid ? half_reg  : 1'b0;
    end
endmodule

// File: doc/insn_sequencer.md
Name: insn_sequencer

Overview:
- Instruction-fetch sequencer in front of the micro-BESM instruction decoder.
- Fetches 64-bit instruction words from memory, holds one word, and presents it to an internal `decoder` instance. The left half is presented first with tkk=0, then the right half with tkk=1.
- Hands each decoded half-instruction to execution over a valid/ready handshake.
- Handles control-transfer redirects, including to either half-word.

Parameters:
- AW, 15, word-address width of PC and memory address.
- START_PC, 0, PC loaded at reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- pe  input  1  BESM-6 compatibility mode; passed straight to decoder.
- mem_req  output  1  fetch request; held high until granted.
- mem_addr  output  AW  word address of the fetch.
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  read data valid; arrives at least 1 cycle after grant.
- mem_rdata  input  64  instruction word.
- insn_valid  output  1  decoded half-instruction available.
- insn_ready  input  1  consumer accepts.
- insn_ir  output  4  modifier index, from decoder.
- insn_op  output  8  opcode, from decoder.
- insn_extop  output  1  extended-opcode flag, from decoder.
- insn_addr  output  20  address field, from decoder.
- insn_pc  output  AW  word address of the presented instruction.
- insn_tkk  output  1  0 = left half, 1 = right half.
- redirect  input  1  transfer of control.
- redirect_pc  input  AW  target word address.
- redirect_tkk  input  1  target half.
- busy  output  1  a fetch is outstanding.

Behaviour:
- Reset values: all outputs 0 except mem_addr = START_PC; pc = START_PC; half = 0; state = FETCH.
- Only one fetch may be outstanding at a time. mem_addr is stable while mem_req is high.
- FETCH: mem_req = 1, mem_addr = pc. On mem_gnt, drop mem_req, set busy = 1, go to WAIT.
- WAIT: on mem_rvalid:
  - If the discard flag is set, clear it and go to FETCH.
  - Otherwise latch mem_rdata into the word register, clear busy, and go to ISSUE.
- ISSUE:
  - Outputs: insn_valid = 1; decoder sees (word register, pe, half); insn_pc = pc; insn_tkk = half.
  - Decoded fields stay stable while insn_valid && !insn_ready.
  - Accept with half = 0: set half = 1 on the next cycle and stay in ISSUE. This gives one half-instruction per cycle under continuous ready.
  - Accept with half = 1: pc = pc + 1 (wraps modulo 2^AW), half = 0, go to FETCH.
- Throughput: minimum 1 cycle of latency from mem_rvalid to insn_valid (registered word). No bubble between the two halves.
- Redirect (any state, highest priority):
  - Next cycle: pc = redirect_pc, half = redirect_tkk, insn_valid = 0, go to FETCH.
  - A handshake completing in the same cycle as the redirect counts as consumed, but its pc/half advance is overridden by the redirect.
  - If a redirect arrives in WAIT, or in FETCH while mem_gnt = 1, the in-flight data is discarded: set the discard flag, wait for mem_rvalid, then refetch.
  - If a redirect arrives in FETCH without grant, update mem_addr next cycle. mem_req may stay high, but mem_addr changes only after the redirect cycle.
  - A redirect with redirect_tkk = 1 fetches the word and issues only the right half.
- pe may change at any time and affects decoding combinationally.
- Asynchronous reset mid-fetch: all state returns to reset values. The memory side must tolerate an abandoned request.

Optional Feature:
- PREFETCH_EN:
  - Defined: adds a second 64-bit word buffer. While in ISSUE with half = 1, the next word (pc+1) is fetched. A right-half accept then proceeds directly to ISSUE with no refetch when the buffer is full; if the buffer is still in flight, it goes to WAIT. A redirect invalidates the buffer and discards any prefetch in flight via the discard flag.
  - Undefined: behaviour exactly as above, with no second buffer.

Test Plan:
- Linear fetch: reset, grant immediately, rvalid 1 cycle after grant, word 0x8000_003F_0000_1234 at address 0, ready held 1 → mem_addr 0; insn_valid with tkk=0 then tkk=1 on consecutive cycles, both insn_pc=0; next mem_addr=1; decoded fields match the decoder for pe=0 and pe=1.
- Backpressure: insn_ready=0 for 5 cycles in ISSUE → insn_valid stays 1 and insn_op/insn_addr/insn_tkk are unchanged; with ready=1, advance to the right half.
- Redirect to right half: redirect_pc=0x0123, redirect_tkk=1 during left-half issue → next mem_addr=0x0123; only the tkk=1 instruction is issued with insn_pc=0x0123; then mem_addr=0x0124.
- Redirect during WAIT: redirect while rvalid is pending → the first returned word is dropped (no insn_valid) and a new request is issued to the target address.
- Wrap: pc=0x7FFF, both halves accepted → next mem_addr=0x0000.
- Reset mid-operation: assert reset_n=0 asynchronously during ISSUE → insn_valid, mem_req and busy drop immediately; after release, fetch resumes at START_PC.
